// File: rtl/spi_pkg.sv
// Shared state encoding and frame sizing for the SPI pair sender.
package spi_pkg;

  localparam int WORD_W_DEF = 16;
  localparam int FRAME_W    = 2 * WORD_W_DEF;

  // Wide enough to hold the count of shifted bits up to and including FRAME_W.
  function automatic int bitCntWidth(input int frameBits);
    return $clog2(frameBits) + 1;
  endfunction

  localparam int BIT_CNT_W = bitCntWidth(FRAME_W);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    DONE
  } spi_tx_state_t;

endpackage

// File: rtl/spi_send_pair_half_period_tick.sv
// Divider that pulses tick once every CLK_DIV enabled cycles; dropping en restarts the count.
module half_period_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic areset,
  input  logic en,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] count_q, count_d;

  assign tick = en && (count_q == LAST);

  always_comb begin
    count_d = count_q + 1'b1;
    if (!en || tick) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!areset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/spi_send_pair.sv
// SPI mode-0 initiator sending {p1,p2} MSB first under load framing.
// Define SPI_SEND_RX_CAPTURE_EN to also capture the responder's echo on sdi into rx_word.
module spi_send_pair
  import spi_pkg::*;
#(
  parameter int WORD_W  = WORD_W_DEF,
  parameter int CLK_DIV = 4
) (
  input  logic                  clk,
  input  logic                  areset,
  input  logic                  start,
  input  logic [WORD_W-1:0]     p1,
  input  logic [WORD_W-1:0]     p2,
  output logic                  busy,
  output logic                  done,
  output logic                  sck,
  output logic                  sdo,
  output logic                  load,
  input  logic                  sdi,
  output logic [2*WORD_W-1:0]   rx_word
);

  localparam int FRAME_LEN = 2 * WORD_W;
  localparam int CNT_W     = bitCntWidth(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_LEN - 1);

  spi_tx_state_t          state_q, state_d;
  logic [FRAME_LEN-1:0]   shiftReg_q, shiftReg_d;
  logic [CNT_W-1:0]       bitCnt_q, bitCnt_d;
  logic                   sck_q, sck_d;
  logic                   sdo_q, sdo_d;
  logic                   tickEn;
  logic                   tick;

  // The divider keeps running from SETUP through HOLD so every phase is a whole half-period.
  assign tickEn = (state_q == SETUP) || (state_q == SHIFT) || (state_q == HOLD);

  half_period_tick #(
    .CLK_DIV(CLK_DIV)
  ) uTick (
    .clk   (clk),
    .areset(areset),
    .en    (tickEn),
    .tick  (tick)
  );

  assign busy = tickEn;
  assign load = tickEn;
  assign done = (state_q == DONE);
  assign sck  = sck_q;
  assign sdo  = sdo_q;

  always_comb begin
    state_d    = state_q;
    shiftReg_d = shiftReg_q;
    bitCnt_d   = bitCnt_q;
    sck_d      = sck_q;
    sdo_d      = sdo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          shiftReg_d = {p1, p2};
          sdo_d      = p1[WORD_W-1];
          bitCnt_d   = '0;
          state_d    = SETUP;
        end
      end
      SETUP: begin
        // The end of SETUP is the first rising edge of the frame.
        if (tick) begin
          sck_d   = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (tick) begin
          if (!sck_q) begin
            sck_d = 1'b1;
          end else begin
            sck_d      = 1'b0;
            shiftReg_d = shiftReg_q << 1;
            bitCnt_d   = bitCnt_q + 1'b1;
            if (bitCnt_q == LAST_BIT) begin
              state_d = HOLD;
            end else begin
              sdo_d = shiftReg_q[FRAME_LEN-2];
            end
          end
        end
      end
      HOLD: begin
        if (tick) begin
          sdo_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!areset) begin
      state_q    <= IDLE;
      shiftReg_q <= '0;
      bitCnt_q   <= '0;
      sck_q      <= 1'b0;
      sdo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shiftReg_q <= shiftReg_d;
      bitCnt_q   <= bitCnt_d;
      sck_q      <= sck_d;
      sdo_q      <= sdo_d;
    end
  end

`ifdef SPI_SEND_RX_CAPTURE_EN
  logic [FRAME_LEN-1:0] rxShift_q, rxShift_d;
  logic [FRAME_LEN-1:0] rxWord_q, rxWord_d;
  logic                 riseEvt;
  logic                 endEvt;

  assign riseEvt = tick && ((state_q == SETUP) || ((state_q == SHIFT) && !sck_q));
  assign endEvt  = tick && (state_q == HOLD);
  assign rx_word = rxWord_q;

  always_comb begin
    rxShift_d = rxShift_q;
    rxWord_d  = rxWord_q;
    if (riseEvt) begin
      rxShift_d = {rxShift_q[FRAME_LEN-2:0], sdi};
    end
    if (endEvt) begin
      rxWord_d = rxShift_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!areset) begin
      rxShift_q <= '0;
      rxWord_q  <= '0;
    end else begin
      rxShift_q <= rxShift_d;
      rxWord_q  <= rxWord_d;
    end
  end
`else
  logic unusedSdi;

  assign unusedSdi = sdi;
  assign rx_word   = '0;
`endif

endmodule

// File: tb/tb_spi_send_pair.sv
// Scoreboard bench for spi_send_pair: a CLK_DIV=4 and a CLK_DIV=1 instance share one monitor/responder.
`timescale 1ns/1ps
module tb_spi_send_pair;

  typedef struct {
    logic [31:0] tx;
    logic [31:0] rx;
  } exp_t;

  typedef struct {
    logic [31:0] bits;
    int          rises;
    int          loadRise;
    int          loadHigh;
    int          firstRise;
    int          doneCyc;
    bit          gapBad;
    logic [31:0] rx;
  } obs_t;

`ifdef SPI_SEND_RX_CAPTURE_EN
  localparam bit RX_EN = 1'b1;
`else
  localparam bit RX_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        areset = 1'b0;
  logic        start4 = 1'b0;
  logic        start1 = 1'b0;
  logic        sdi = 1'b0;
  logic [15:0] p1 = '0;
  logic [15:0] p2 = '0;
  logic        busy4, done4, sck4, sdo4, load4;
  logic        busy1, done1, sck1, sdo1, load1;
  logic [31:0] rx4, rx1;

  logic [31:0] rxPattern = 32'h1234_ABCD;
  logic [31:0] expRx;
  bit          sel = 1'b0;
  int          cyc = 0;
  int          checkCnt = 0;
  int          passCnt = 0;

  exp_t expQ[$];
  obs_t obsQ[$];

  obs_t        cur;
  int          lastRise = 0;
  int          fallCnt = 0;
  logic        prevSck = 1'b0;
  logic        prevLoad = 1'b0;
  logic        sckS, sdoS, loadS, doneS;
  logic [31:0] rxS;
  int          halfP;

  spi_send_pair #(.WORD_W(16), .CLK_DIV(4)) dut4 (
    .clk(clk), .areset(areset), .start(start4), .p1(p1), .p2(p2),
    .busy(busy4), .done(done4), .sck(sck4), .sdo(sdo4), .load(load4),
    .sdi(sdi), .rx_word(rx4)
  );

  spi_send_pair #(.WORD_W(16), .CLK_DIV(1)) dut1 (
    .clk(clk), .areset(areset), .start(start1), .p1(p1), .p2(p2),
    .busy(busy1), .done(done1), .sck(sck1), .sdo(sdo1), .load(load1),
    .sdi(sdi), .rx_word(rx1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Receiver model of the selected DUT plus a mode-0 responder that shifts rxPattern out on sdi.
  always @(negedge clk) begin
    sckS  = sel ? sck1 : sck4;
    sdoS  = sel ? sdo1 : sdo4;
    loadS = sel ? load1 : load4;
    doneS = sel ? done1 : done4;
    rxS   = sel ? rx1 : rx4;
    halfP = sel ? 1 : 4;
    if (loadS && !prevLoad) begin
      cur = '{default: 0};
      cur.loadRise = cyc;
    end
    if (loadS) cur.loadHigh++;
    if (sckS && !prevSck) begin
      if (cur.rises == 0) cur.firstRise = cyc;
      else if (cyc - lastRise != 2 * halfP) cur.gapBad = 1'b1;
      lastRise = cyc;
      cur.rises++;
      cur.bits = {cur.bits[30:0], sdoS};
    end
    if (!sckS && prevSck) fallCnt++;
    if (!loadS) fallCnt = 0;
    sdi = (fallCnt < 32) ? rxPattern[31 - fallCnt] : 1'b0;
    if (doneS) begin
      cur.doneCyc = cyc;
      cur.rx = rxS;
      obsQ.push_back(cur);
    end
    prevSck  = sckS;
    prevLoad = loadS;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic waitFrames(input int n, input int budget, output bit ok);
    int k = 0;
    while (obsQ.size() < n && k < budget) begin
      step();
      k++;
    end
    ok = (obsQ.size() >= n);
  endtask

  task automatic pushExpected();
    exp_t e;
    e.tx = {p1, p2};
    e.rx = expRx;
    expQ.push_back(e);
  endtask

  task automatic test_reset();
    areset = 1'b0;
    repeat (3) step();
    checkCnt++;
    if ({sck4, sdo4, load4, busy4, done4} !== 5'b0)
      $display("[TB] FAIL reset_ctl4: got %b want 00000", {sck4, sdo4, load4, busy4, done4});
    else passCnt++;
    checkCnt++;
    if (rx4 !== 32'h0) $display("[TB] FAIL reset_rx4: got %h want 0", rx4);
    else passCnt++;
    checkCnt++;
    if ({sck1, sdo1, load1, busy1, done1} !== 5'b0)
      $display("[TB] FAIL reset_ctl1: got %b want 00000", {sck1, sdo1, load1, busy1, done1});
    else passCnt++;
    checkCnt++;
    if (rx1 !== 32'h0) $display("[TB] FAIL reset_rx1: got %h want 0", rx1);
    else passCnt++;
    areset = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_single_frame();
    obs_t o;
    exp_t e;
    int   t0;
    bit   ok;
    sel = 1'b0;
    p1 = 16'hA5C3;
    p2 = 16'h0F81;
    pushExpected();
    start4 = 1'b1;
    t0 = cyc;
    step();
    start4 = 1'b0;
    waitFrames(1, 400, ok);
    checkCnt++;
    if (!ok) begin
      $display("[TB] FAIL single_done_timeout: got no done want done within 400 cycles");
      expQ.delete();
    end else begin
      passCnt++;
      o = obsQ.pop_front();
      e = expQ.pop_front();
      checkCnt++;
      if (o.bits !== e.tx) $display("[TB] FAIL single_bits: got %h want %h", o.bits, e.tx);
      else passCnt++;
      checkCnt++;
      if (o.rises !== 32) $display("[TB] FAIL single_rises: got %0d want 32", o.rises);
      else passCnt++;
      checkCnt++;
      if (o.loadRise !== t0 + 1) $display("[TB] FAIL single_load_rise: got %0d want %0d", o.loadRise, t0 + 1);
      else passCnt++;
      checkCnt++;
      if (o.loadHigh !== 260) $display("[TB] FAIL single_load_len: got %0d want 260", o.loadHigh);
      else passCnt++;
      checkCnt++;
      if (o.doneCyc !== t0 + 261) $display("[TB] FAIL single_done_cyc: got %0d want %0d", o.doneCyc, t0 + 261);
      else passCnt++;
      checkCnt++;
      if (o.firstRise !== t0 + 5) $display("[TB] FAIL single_first_rise: got %0d want %0d", o.firstRise, t0 + 5);
      else passCnt++;
      checkCnt++;
      if (o.gapBad !== 1'b0) $display("[TB] FAIL single_sck_period: got irregular want 8 cycles");
      else passCnt++;
      checkCnt++;
      if (o.rx !== e.rx) $display("[TB] FAIL single_rx: got %h want %h", o.rx, e.rx);
      else passCnt++;
    end
    repeat (3) step();
  endtask

  task automatic test_reset_mid_frame();
    obs_t o;
    exp_t e;
    bit   ok;
    sel = 1'b0;
    p1 = 16'h5A5A;
    p2 = 16'hC3C3;
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    repeat (99) step();
    checkCnt++;
    if (busy4 !== 1'b1) $display("[TB] FAIL midrst_busy_before: got %b want 1", busy4);
    else passCnt++;
    areset = 1'b0;
    step();
    checkCnt++;
    if ({sck4, load4, sdo4, busy4, done4} !== 5'b0)
      $display("[TB] FAIL midrst_outputs: got %b want 00000", {sck4, load4, sdo4, busy4, done4});
    else passCnt++;
    checkCnt++;
    if (rx4 !== 32'h0) $display("[TB] FAIL midrst_rx: got %h want 0", rx4);
    else passCnt++;
    areset = 1'b1;
    repeat (300) step();
    checkCnt++;
    if (obsQ.size() !== 0) $display("[TB] FAIL midrst_no_done: got %0d done pulses want 0", obsQ.size());
    else passCnt++;
    obsQ.delete();
    p1 = 16'h3C96;
    p2 = 16'h8001;
    pushExpected();
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    waitFrames(1, 400, ok);
    checkCnt++;
    if (!ok) begin
      $display("[TB] FAIL midrst_fresh_timeout: got no done want done within 400 cycles");
      expQ.delete();
    end else begin
      passCnt++;
      o = obsQ.pop_front();
      e = expQ.pop_front();
      checkCnt++;
      if (o.bits !== e.tx) $display("[TB] FAIL midrst_fresh_bits: got %h want %h", o.bits, e.tx);
      else passCnt++;
      checkCnt++;
      if (o.rises !== 32) $display("[TB] FAIL midrst_fresh_rises: got %0d want 32", o.rises);
      else passCnt++;
      checkCnt++;
      if (o.rx !== e.rx) $display("[TB] FAIL midrst_fresh_rx: got %h want %h", o.rx, e.rx);
      else passCnt++;
    end
    repeat (3) step();
  endtask

  task automatic test_back_to_back();
    obs_t f1, f2;
    exp_t e1, e2;
    int   t0;
    bit   ok;
    sel = 1'b0;
    p1 = 16'hBEEF;
    p2 = 16'h1357;
    pushExpected();
    start4 = 1'b1;
    t0 = cyc;
    repeat (50) step();
    // Frame one must ignore this; frame two latches it on re-accept.
    p1 = 16'h0246;
    p2 = 16'hFACE;
    pushExpected();
    waitFrames(1, 400, ok);
    repeat (3) step();
    start4 = 1'b0;
    waitFrames(2, 400, ok);
    repeat (300) step();
    checkCnt++;
    if (obsQ.size() !== 2) begin
      $display("[TB] FAIL b2b_frame_count: got %0d want 2", obsQ.size());
      obsQ.delete();
      expQ.delete();
    end else begin
      passCnt++;
      f1 = obsQ.pop_front();
      f2 = obsQ.pop_front();
      e1 = expQ.pop_front();
      e2 = expQ.pop_front();
      checkCnt++;
      if (f1.bits !== e1.tx) $display("[TB] FAIL b2b_frame1_bits: got %h want %h", f1.bits, e1.tx);
      else passCnt++;
      checkCnt++;
      if (f2.bits !== e2.tx) $display("[TB] FAIL b2b_frame2_bits: got %h want %h", f2.bits, e2.tx);
      else passCnt++;
      checkCnt++;
      if (f1.loadRise !== t0 + 1) $display("[TB] FAIL b2b_first_load: got %0d want %0d", f1.loadRise, t0 + 1);
      else passCnt++;
      checkCnt++;
      if (f2.loadRise - f1.doneCyc !== 2)
        $display("[TB] FAIL b2b_gap: got %0d want 2", f2.loadRise - f1.doneCyc);
      else passCnt++;
      checkCnt++;
      if (f2.rises !== 32) $display("[TB] FAIL b2b_frame2_rises: got %0d want 32", f2.rises);
      else passCnt++;
    end
    repeat (3) step();
  endtask

  task automatic test_clkdiv1();
    obs_t o;
    exp_t e;
    int   t0;
    bit   ok;
    sel = 1'b1;
    p1 = 16'hFFFF;
    p2 = 16'h0000;
    pushExpected();
    start1 = 1'b1;
    t0 = cyc;
    step();
    start1 = 1'b0;
    waitFrames(1, 200, ok);
    checkCnt++;
    if (!ok) begin
      $display("[TB] FAIL div1_done_timeout: got no done want done within 200 cycles");
      expQ.delete();
    end else begin
      passCnt++;
      o = obsQ.pop_front();
      e = expQ.pop_front();
      checkCnt++;
      if (o.bits !== e.tx) $display("[TB] FAIL div1_bits: got %h want %h", o.bits, e.tx);
      else passCnt++;
      checkCnt++;
      if (o.rises !== 32) $display("[TB] FAIL div1_rises: got %0d want 32", o.rises);
      else passCnt++;
      checkCnt++;
      if (o.gapBad !== 1'b0) $display("[TB] FAIL div1_sck_period: got irregular want 2 cycles");
      else passCnt++;
      checkCnt++;
      if (o.doneCyc !== t0 + 66) $display("[TB] FAIL div1_done_cyc: got %0d want %0d", o.doneCyc, t0 + 66);
      else passCnt++;
      checkCnt++;
      if (o.loadHigh !== 65) $display("[TB] FAIL div1_load_len: got %0d want 65", o.loadHigh);
      else passCnt++;
      checkCnt++;
      if (o.firstRise !== t0 + 2) $display("[TB] FAIL div1_first_rise: got %0d want %0d", o.firstRise, t0 + 2);
      else passCnt++;
      checkCnt++;
      if (o.rx !== e.rx) $display("[TB] FAIL div1_rx: got %h want %h", o.rx, e.rx);
      else passCnt++;
    end
    sel = 1'b0;
    repeat (3) step();
  endtask

  initial begin
    expRx = RX_EN ? rxPattern : 32'h0;
    test_reset();
    test_single_frame();
    test_reset_mid_frame();
    test_back_to_back();
    test_clkdiv1();
    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got simulation still running want finish before 1 ms");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/spi_send_pair.md
Name: spi_send_pair

Overview:
- FPGA-side SPI initiator that serialises a pair of 16-bit words (p1, then p2) onto an sck/sdo/load link.
- Produces exactly the framing that spi_receive_only consumes.
- Used as an on-chip stimulus/loopback driver for spi_receive_only, and as the link driver when a second FPGA board must forward p1/p2 voltage samples.
- Optionally captures the responder's sdo echo during the same frame.

Parameters:
- WORD_W, 16, width of each word (p1, p2).
- CLK_DIV, 4, clk cycles per sck half-period; legal range is 1 and above.

Ports:
- clk  input  1  system clock.
- areset  input  1  synchronous, active-low reset.
- start  input  1  request to send a frame; sampled only in IDLE.
- p1  input  WORD_W  first word, sent MSB first.
- p2  input  WORD_W  second word, sent MSB first after p1.
- busy  output  1  high from the cycle after start is accepted through the last HOLD cycle.
- done  output  1  one-cycle pulse at frame completion.
- sck  output  1  SPI clock; idle low (mode 0).
- sdo  output  1  serial data to responder sdi.
- load  output  1  frame enable; high for the whole frame.
- sdi  input  1  serial data from responder sdo.
- rx_word  output  2*WORD_W  captured sdi bits (see Optional Feature).

Behaviour:
- Reset (areset low at a clk edge): state IDLE; sck=0, sdo=0, load=0, busy=0, done=0, rx_word=0, shift register=0, divider=0.
- Reset applies mid-frame too: all outputs reach these values on that edge, and no done pulse is produced.
- FSM states and transitions: IDLE -> SETUP -> SHIFT -> HOLD -> DONE -> IDLE.
- IDLE:
  - start=1 latches {p1,p2} into a 32-bit shift register.
  - Next state is SETUP.
  - Later changes on p1/p2 do not affect the frame in flight.
- SETUP (lasts CLK_DIV cycles):
  - load=1, sdo=shreg[MSB], sck=0.
- SHIFT:
  - Divider tick every CLK_DIV cycles toggles sck.
  - On a rising toggle, sdi is sampled into the rx shift register.
  - On a falling toggle, shreg shifts left and sdo takes the new MSB.
  - After the 32nd falling toggle, next state is HOLD.
  - Frame carries exactly 32 rising edges.
- HOLD (lasts CLK_DIV cycles):
  - sck=0, load=1, sdo holds its last value.
- DONE (one cycle):
  - load=0, done=1, busy=0, sdo=0; rx_word updated.
  - Next state is IDLE.
- Timing, with start accepted at cycle 0:
  - load is high over cycles 1 .. 65*CLK_DIV.
  - done pulses at cycle 1+65*CLK_DIV.
  - Rising edge k (k = 0..31) occurs at cycle 1+(2k+1)*CLK_DIV.
- start while busy, or during the DONE cycle, is ignored; it is neither queued nor latched.
- Back-to-back frames: earliest re-accept is the cycle after DONE, so load is low for at least 2 cycles between frames.
- CLK_DIV=1: sck toggles every cycle; the same edge counts hold.

Optional Feature:
- Macro SPI_SEND_RX_CAPTURE_EN.
- Defined: sdi is sampled on each sck rising edge and rx_word is loaded from the rx shift register in DONE, first sampled bit at the MSB.
- Undefined: there is no rx shift register, rx_word is tied to 0, and sdi is unused.

Decomposition:
- Package spi_pkg holds:
  - WORD_W_DEF = 16.
  - FRAME_W = 2*WORD_W_DEF.
  - typedef enum logic [2:0] spi_tx_state_t {IDLE, SETUP, SHIFT, HOLD, DONE}.
  - Bit-counter width constant, $clog2(FRAME_W)+1.
- Sub-module half_period_tick (parameter CLK_DIV):
  - Ports clk, areset, en, tick.
  - tick is high one cycle every CLK_DIV enabled cycles.
  - Counter clears when en=0.

Test Plan:
- Single frame: CLK_DIV=4, p1=16'hA5C3, p2=16'h0F81, start pulsed at cycle 0.
  - Loopback into spi_receive_only yields p1=A5C3 and p2=0F81.
  - load high cycles 1..260, done at 261, 32 sck rising edges.
- Reset mid-frame: areset low at cycle 100.
  - Next edge gives sck=0, load=0, sdo=0, busy=0.
  - No done pulse.
  - A fresh start afterwards sends a correct frame.
- Start while busy: start held high for the whole frame.
  - Exactly one frame per IDLE visit.
  - The second frame's load rises 2 cycles after the first done.
  - Input changes mid-frame do not alter transmitted bits.
- CLK_DIV=1 boundary: p1=16'hFFFF, p2=16'h0000.
  - sck period is 2 cycles.
  - Bits 31..16 are 1 and bits 15..0 are 0 at each rising edge.
  - done at cycle 66.
- With SPI_SEND_RX_CAPTURE_EN defined, sdi driven from a 32'h1234_ABCD responder model:
  - rx_word = 32'h1234ABCD in the DONE cycle.
  - With the macro undefined, rx_word stays 0.
